// File: rtl/usb_bulk_echo_engine.sv
// Bulk echo engine: drains bytes from the EP2 OUT FIFO and writes them, XOR-masked,
// into the EP3 IN FIFO, with echo, stall and flush-drop statistics for the Pmod display.
module usb_bulk_echo_engine #(
   parameter logic [7:0] XOR_MASK = 8'h00,
   parameter int         CNT_W    = 16,
   parameter int         STALL_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [7:0]         ep2_dout,
   output logic               ep2_re,
   input  logic [3:0]         ep2_stat,
   output logic [7:0]         ep3_din,
   output logic               ep3_we,
   input  logic [3:0]         ep3_stat,
   input  logic               clr_bulk,
   output logic [CNT_W-1:0]   byte_cnt,
   output logic [STALL_W-1:0] stall_cnt,
   output logic [7:0]         drop_cnt,
   output logic [7:0]         last_byte,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      XMIT
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         hold_q, hold_d;
   logic               ep2_re_q, ep2_re_d;
   logic               ep3_we_q, ep3_we_d;
   logic [7:0]         ep3_din_q, ep3_din_d;
   logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [7:0]         drop_cnt_q, drop_cnt_d;
   logic [7:0]         last_byte_q, last_byte_d;

   logic ep2_empty;
   logic ep3_full;
   logic unused_stat;

   assign ep2_empty   = ep2_stat[1];
   assign ep3_full    = ep3_stat[0];
   assign unused_stat = ^{ep2_stat[3:2], ep2_stat[0], ep3_stat[3:1]};

   // A flush abandons whatever byte is in flight; it never reaches EP3.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      ep2_re_d    = 1'b0;
      ep3_we_d    = 1'b0;
      ep3_din_d   = ep3_din_q;
      byte_cnt_d  = byte_cnt_q;
      stall_cnt_d = stall_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      last_byte_d = last_byte_q;

      case (state_q)
         IDLE: begin
            if (!clr_bulk && enable && !ep2_empty) begin
               ep2_re_d = 1'b1;
               state_d  = FETCH;
            end
         end

         FETCH: begin
            if (clr_bulk) begin
               if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
               state_d = IDLE;
            end else begin
               hold_d  = ep2_dout;
               state_d = XMIT;
            end
         end

         XMIT: begin
            if (clr_bulk) begin
               if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
               state_d = IDLE;
            end else if (!ep3_full) begin
               ep3_din_d   = hold_q ^ XOR_MASK;
               ep3_we_d    = 1'b1;
               last_byte_d = hold_q ^ XOR_MASK;
               byte_cnt_d  = byte_cnt_q + CNT_W'(1);
               state_d     = IDLE;
            end else if (stall_cnt_q != {STALL_W{1'b1}}) begin
               stall_cnt_d = stall_cnt_q + STALL_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         hold_q      <= 8'h00;
         ep2_re_q    <= 1'b0;
         ep3_we_q    <= 1'b0;
         ep3_din_q   <= 8'h00;
         byte_cnt_q  <= '0;
         stall_cnt_q <= '0;
         drop_cnt_q  <= 8'h00;
         last_byte_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         ep2_re_q    <= ep2_re_d;
         ep3_we_q    <= ep3_we_d;
         ep3_din_q   <= ep3_din_d;
         byte_cnt_q  <= byte_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         last_byte_q <= last_byte_d;
      end
   end

   assign ep2_re    = ep2_re_q;
   assign ep3_we    = ep3_we_q;
   assign ep3_din   = ep3_din_q;
   assign byte_cnt  = byte_cnt_q;
   assign stall_cnt = stall_cnt_q;
   assign drop_cnt  = drop_cnt_q;
   assign last_byte = last_byte_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_usb_bulk_echo_engine.sv
// Bench for the bulk echo engine: per-cycle stimulus tables are turned into an expected
// timeline by a transaction-level model, then replayed against two DUTs (mask 00 and FF).
module tb_usb_bulk_echo_engine;

   localparam int         NC     = 300;
   localparam int         NB     = 64;
   localparam logic [7:0] MASK_A = 8'h00;
   localparam logic [7:0] MASK_B = 8'hFF;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       enable   = 1'b0;
   logic       clr_bulk = 1'b0;
   logic [7:0] ep2_dout = 8'h00;
   logic [3:0] ep2_stat = 4'b0010;
   logic [3:0] ep3_stat = 4'b0000;

   logic        ep2_re_a, ep3_we_a, busy_a;
   logic [7:0]  ep3_din_a, drop_cnt_a, last_byte_a;
   logic [15:0] byte_cnt_a, stall_cnt_a;
   logic        ep2_re_b, ep3_we_b, busy_b;
   logic [7:0]  ep3_din_b, drop_cnt_b, last_byte_b;
   logic [15:0] byte_cnt_b, stall_cnt_b;

   always #5 clk = ~clk;

   usb_bulk_echo_engine #(.XOR_MASK(MASK_A), .CNT_W(16), .STALL_W(16)) dut_a (
      .clk(clk), .reset(reset), .enable(enable),
      .ep2_dout(ep2_dout), .ep2_re(ep2_re_a), .ep2_stat(ep2_stat),
      .ep3_din(ep3_din_a), .ep3_we(ep3_we_a), .ep3_stat(ep3_stat),
      .clr_bulk(clr_bulk), .byte_cnt(byte_cnt_a), .stall_cnt(stall_cnt_a),
      .drop_cnt(drop_cnt_a), .last_byte(last_byte_a), .busy(busy_a)
   );

   usb_bulk_echo_engine #(.XOR_MASK(MASK_B), .CNT_W(16), .STALL_W(16)) dut_b (
      .clk(clk), .reset(reset), .enable(enable),
      .ep2_dout(ep2_dout), .ep2_re(ep2_re_b), .ep2_stat(ep2_stat),
      .ep3_din(ep3_din_b), .ep3_we(ep3_we_b), .ep3_stat(ep3_stat),
      .clr_bulk(clr_bulk), .byte_cnt(byte_cnt_b), .stall_cnt(stall_cnt_b),
      .drop_cnt(drop_cnt_b), .last_byte(last_byte_b), .busy(busy_b)
   );

   bit         sEn[NC], sEmpty[NC], sFull[NC], sClr[NC], sRst[NC];
   logic [7:0] fifoMem[NB];
   int         fifoLen;

   bit         expRe[NC], expWe[NC], expBusy[NC];
   logic [7:0] expDin[NC], expDin2[NC], expLast[NC], expLast2[NC];
   int         expCnt[NC], expStall[NC], expDrop[NC];
   int         mCnt, mStall, mDrop;
   logic [7:0] mLast, mLast2;

   int    tbChecks   = 0;
   int    tbFailures = 0;
   string curScen    = "";
   int    curCycle   = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tbChecks++;
      if (obs !== exp) begin
         tbFailures++;
         $display("[TB] FAIL %s/%s cycle=%0d got=%0h exp=%0h", curScen, tag, curCycle, obs, exp);
      end
   endtask

   task automatic clearStim();
      for (int i = 0; i < NC; i++) begin
         sEn[i] = 0; sEmpty[i] = 0; sFull[i] = 0; sClr[i] = 0; sRst[i] = 0;
      end
      fifoLen = 0;
   endtask

   task automatic setFrom(input int k);
      for (int i = k; i < NC; i++) begin
         expCnt[i]   = mCnt;
         expStall[i] = mStall;
         expDrop[i]  = mDrop;
         expLast[i]  = mLast;
         expLast2[i] = mLast2;
      end
   endtask

   task automatic zeroModel(input int k);
      mCnt = 0; mStall = 0; mDrop = 0; mLast = 8'h00; mLast2 = 8'h00;
      setFrom(k);
   endtask

   // Each byte: a read decision in an idle cycle, one fetch cycle, then transmit
   // cycles until the IN FIFO has room, a flush, or a reset ends it.
   task automatic buildModel();
      int t, f, c, rd;
      logic [7:0] data;
      for (int i = 0; i < NC; i++) begin
         expRe[i] = 0; expWe[i] = 0; expBusy[i] = 0; expDin[i] = 8'h00; expDin2[i] = 8'h00;
      end
      zeroModel(0);
      rd = 0;
      t  = 0;
      while (t < NC) begin
         if (sRst[t]) begin
            zeroModel(t + 1);
            t++;
         end else if (!sEn[t] || sClr[t] || sEmpty[t] || rd >= fifoLen) begin
            t++;
         end else begin
            f = t + 1;
            if (f >= NC) break;
            expRe[f]   = 1;
            expBusy[f] = 1;
            data = fifoMem[rd];
            rd++;
            if (sRst[f]) begin
               zeroModel(f + 1);
               t = f + 1;
            end else if (sClr[f]) begin
               if (mDrop < 255) mDrop++;
               setFrom(f + 1);
               t = f + 1;
            end else begin
               c = f + 1;
               t = NC;
               while (c < NC) begin
                  expBusy[c] = 1;
                  if (sRst[c]) begin
                     zeroModel(c + 1);
                     t = c + 1;
                     break;
                  end else if (sClr[c]) begin
                     if (mDrop < 255) mDrop++;
                     setFrom(c + 1);
                     t = c + 1;
                     break;
                  end else if (sFull[c]) begin
                     if (mStall < 65535) mStall++;
                     setFrom(c + 1);
                     c++;
                  end else begin
                     mCnt   = (mCnt + 1) % 65536;
                     mLast  = data ^ MASK_A;
                     mLast2 = data ^ MASK_B;
                     if (c + 1 < NC) begin
                        expWe[c + 1]   = 1;
                        expDin[c + 1]  = mLast;
                        expDin2[c + 1] = mLast2;
                     end
                     setFrom(c + 1);
                     t = c + 1;
                     break;
                  end
               end
            end
         end
      end
   endtask

   // Inputs change on the falling edge; the bench's OUT FIFO pops one cycle after it sees ep2_re.
   task automatic applyStimulus(input string name);
      int rdB;
      bit prevRe;
      curScen = name;
      buildModel();
      reset    = 1'b1;
      enable   = 1'b0;
      clr_bulk = 1'b0;
      ep2_stat = 4'b0010;
      ep3_stat = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      rdB    = 0;
      prevRe = 0;
      for (int t = 0; t < NC; t++) begin
         if (prevRe) rdB++;
         curCycle = t;
         checkOutput("ep2_re", ep2_re_a, expRe[t]);
         checkOutput("ep3_we", ep3_we_a, expWe[t]);
         checkOutput("busy", busy_a, expBusy[t]);
         checkOutput("byte_cnt", byte_cnt_a, expCnt[t]);
         checkOutput("stall_cnt", stall_cnt_a, expStall[t]);
         checkOutput("drop_cnt", drop_cnt_a, expDrop[t]);
         checkOutput("last_byte", last_byte_a, expLast[t]);
         checkOutput("last_byte_xor", last_byte_b, expLast2[t]);
         if (expWe[t]) begin
            checkOutput("ep3_din", ep3_din_a, expDin[t]);
            checkOutput("ep3_din_xor", ep3_din_b, expDin2[t]);
         end
         if (t == 0) checkOutput("reset_din", ep3_din_a, 32'h0);
         prevRe   = ep2_re_a;
         reset    = sRst[t];
         enable   = sEn[t];
         clr_bulk = sClr[t];
         ep2_stat = {$urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1,
                     sEmpty[t] || (rdB >= fifoLen), $urandom_range(1, 0) == 1};
         ep3_stat = {3'($urandom_range(7, 0)), sFull[t]};
         ep2_dout = (rdB < fifoLen) ? fifoMem[rdB] : 8'h00;
         @(negedge clk);
      end
   endtask

   initial begin
      clearStim();
      fifoMem[0] = 8'h11; fifoMem[1] = 8'h22; fifoMem[2] = 8'h33; fifoLen = 3;
      for (int i = 0; i < 30; i++) sEn[i] = 1;
      applyStimulus("basic");

      clearStim();
      fifoMem[0] = 8'hA5; fifoLen = 1;
      for (int i = 0; i < 10; i++) sEn[i] = 1;
      applyStimulus("transform");

      clearStim();
      fifoMem[0] = 8'h6B; fifoLen = 1;
      for (int i = 0; i < 20; i++) sEn[i] = 1;
      for (int i = 2; i < 12; i++) sFull[i] = 1;
      applyStimulus("backpressure");

      clearStim();
      fifoMem[0] = 8'h47; fifoMem[1] = 8'h58; fifoLen = 2;
      for (int i = 0; i < 20; i++) sEn[i] = 1;
      for (int i = 2; i < 6; i++) sFull[i] = 1;
      sClr[4] = 1;
      applyStimulus("flush");

      clearStim();
      fifoMem[0] = 8'h3C; fifoLen = 1;
      for (int i = 0; i < 20; i++) begin sEn[i] = 1; sEmpty[i] = 1; end
      sEn[40] = 1;
      applyStimulus("empty_disable");

      clearStim();
      for (int i = 0; i < 8; i++) fifoMem[i] = 8'(8'h81 + 8'(i * 7));
      fifoLen = 8;
      for (int i = 0; i < 60; i++) sEn[i] = 1;
      sRst[16] = 1;
      applyStimulus("reset_mid_op");

      for (int s = 0; s < 8; s++) begin
         clearStim();
         fifoLen = 40;
         for (int i = 0; i < fifoLen; i++) fifoMem[i] = 8'($urandom_range(255, 0));
         for (int i = 0; i < NC - 40; i++) begin
            sEn[i]    = $urandom_range(9, 0) < 8;
            sEmpty[i] = $urandom_range(9, 0) == 0;
            sFull[i]  = $urandom_range(9, 0) < 3;
            sClr[i]   = $urandom_range(29, 0) == 0;
            sRst[i]   = (i > 5) && ($urandom_range(119, 0) == 0);
         end
         applyStimulus($sformatf("random%0d", s));
      end

      $display("TB_RESULT checks=%0d failures=%0d", tbChecks, tbFailures);
      $finish;
   end

endmodule

// File: doc/usb_bulk_echo_engine.md
Name: usb_bulk_echo_engine

Overview:
Endpoint-side client of the USB 1.1 device core. It drains host-to-device bytes from the bulk OUT endpoint FIFO (EP2 read port) and pushes each byte, optionally XOR-transformed, into the bulk IN endpoint FIFO (EP3 write port). The host therefore reads back what it wrote. It sits beside the core in the Nexys3 top level, and its debug outputs drive the Pmod headers.

Parameters:
XOR_MASK, 8'h00, byte XORed onto every echoed byte (00 = pure loopback).
CNT_W, 16, width of the echoed-byte counter (wraps).
STALL_W, 16, width of the IN-full stall counter (saturates).

Ports:
clk  in  1  system clock, single domain
reset  in  1  synchronous, active-high reset
enable  in  1  1 = engine may start new transfers
ep2_dout  in  8  OUT FIFO read data; valid the cycle after ep2_re
ep2_re  out  1  OUT FIFO read strobe, one-cycle pulse
ep2_stat  in  4  OUT FIFO status; bit1 = empty, other bits ignored
ep3_din  out  8  IN FIFO write data
ep3_we  out  1  IN FIFO write strobe, one-cycle pulse
ep3_stat  in  4  IN FIFO status; bit0 = full, other bits ignored
clr_bulk  in  1  bulk FIFO flush request from core/host
byte_cnt  out  CNT_W  bytes written to EP3 since reset (wraps)
stall_cnt  out  STALL_W  cycles spent in XMIT with IN FIFO full (saturates at all-ones)
drop_cnt  out  8  bytes discarded by clr_bulk (saturates at 255)
last_byte  out  8  last byte written to EP3 (for Pmod display)
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (synchronous, clk rising edge with reset=1): state=IDLE. ep2_re=0, ep3_we=0, ep3_din=0, byte_cnt=0, stall_cnt=0, drop_cnt=0, last_byte=0, busy=0, hold=0. Reset has priority over every other input, including mid-transfer; a byte held at that point is lost and not counted.
- All outputs are registered. The strobes are high for exactly one cycle per byte.
- FSM states are IDLE, FETCH, XMIT.
- IDLE: if enable=1 and ep2_stat[1]=0, pulse ep2_re=1 and go to FETCH. Otherwise stay.
- FETCH (cycle after ep2_re): capture hold <= ep2_dout and go to XMIT.
- XMIT, when ep3_stat[0]=0: ep3_din <= hold ^ XOR_MASK, ep3_we <= 1, last_byte <= hold ^ XOR_MASK, byte_cnt <= byte_cnt+1 (mod 2^CNT_W), then go to IDLE.
- XMIT, when ep3_stat[0]=1: hold state. stall_cnt increments by 1 per cycle and saturates; no write is issued.
- Throughput is one byte per 3 cycles when both FIFOs are unobstructed. Latency from the ep2_re pulse to the ep3_we pulse is 2 cycles.
- enable is sampled only in IDLE. Deasserting it in FETCH or XMIT does not abort; the held byte completes.
- Empty handling: ep2_re is never asserted while ep2_stat[1]=1. Full handling: ep3_we is never asserted while ep3_stat[0]=1, sampled in the same cycle.
- clr_bulk=1 takes priority over FSM progress:
  - In FETCH or XMIT: the held byte is discarded, drop_cnt increments (saturating), state goes to IDLE, and no ep3_we is issued that cycle.
  - In IDLE: no read is started that cycle.
  - The engine resumes normally on the first cycle after clr_bulk falls.
- If clr_bulk and ep3 not-full coincide in XMIT, clr_bulk wins: no write, byte dropped.
- busy is combinationally equal to (state != IDLE), computed from registered state.
- No byte is ever duplicated or reordered. Bytes leave EP3 in the order they left EP2.

Test Plan:
- Basic echo (XOR_MASK=00): preload OUT FIFO with 8'h11, 8'h22, 8'h33, IN FIFO never full, enable=1. Required: ep3_we pulses carry 11, 22, 33 in order, 3 cycles apart; each ep3_we is 2 cycles after its ep2_re; byte_cnt=3; last_byte=33; busy=0 after the final write.
- Transform: XOR_MASK=8'hFF, input 8'hA5. Required: ep3_din=8'h5A, last_byte=8'h5A.
- Backpressure: hold ep3_stat[0]=1 for 10 cycles after entering XMIT, then release. Required: no ep3_we during the hold; stall_cnt=10; a single write of the held byte on the first not-full cycle; byte_cnt +1.
- Flush mid-transfer: assert clr_bulk for 1 cycle while in XMIT with IN FIFO full. Required: no write; drop_cnt=1; state=IDLE next cycle; the next OUT byte echoes correctly.
- Empty and disable: ep2_stat[1]=1, or enable=0, for 20 cycles. Required: ep2_re=0 throughout and busy=0. Then deassert enable in FETCH. Required: that byte is still written.
- Reset mid-op: assert reset in FETCH after 5 bytes have been echoed. Required: all counters=0, last_byte=0, no ep3_we after reset; normal echo resumes once reset is released.
